mtr_ebus_reader: RTL

- EBUS-side initiator for the meter (MTR) board: the reader at the other end of the MTR diagnostic-read path and the MTR interrupt request.
- Drives the DIAG function select and READ_MTR. Samples the MTR's registered EBUS data bits 18:35 after a fixed settle time and returns the word to a host/microcode requester.
- Services the MTR interrupt request: asserts honor, reads the interrupt-select word (DS=7) and reports the vector request and increment select.

---
 rtl/mtr_ebus_reader_if.sv | 43 ++++
 rtl/mtr_ebus_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtr_ebus_reader_if.sv
// mtr_ebus_reader_if
//   Bundles the host request/response signals and the MTR-side EBUS
//   signals used by mtr_ebus_reader.
//   master : the reader (drives DIAG select, READ_MTR, honor, host results)
//   slave  : the environment (host requester plus the MTR board)
//   ebus_data / rd_data carry EBUS bits 18:35, with bit n at index 35-n.
//   Optional macro MTR_RD_RETRY_EN adds the rd_err signal.
interface mtr_ebus_reader_if;
  logic        req;
  logic [2:0]  req_sel;
  logic        busy;
  logic        done;
  logic [17:0] rd_data;
  logic [2:0]  ds;
  logic        read_mtr;
  logic [17:0] ebus_data;
  logic        mtr_int_req;
  logic        mtr_honor;
  logic        int_valid;
  logic        int_vector;
  logic [1:0]  int_incr_sel;
`ifdef MTR_RD_RETRY_EN
  logic        rd_err;
`endif

  modport master (
    input  req, req_sel, ebus_data, mtr_int_req,
    output busy, done, rd_data, ds, read_mtr, mtr_honor,
           int_valid, int_vector, int_incr_sel
`ifdef MTR_RD_RETRY_EN
    , output rd_err
`endif
  );

  modport slave (
    output req, req_sel, ebus_data, mtr_int_req,
    input  busy, done, rd_data, ds, read_mtr, mtr_honor,
           int_valid, int_vector, int_incr_sel
`ifdef MTR_RD_RETRY_EN
    , input rd_err
`endif
  );
endinterface

// File: rtl/mtr_ebus_reader.sv
// mtr_ebus_reader
//   EBUS-side initiator for the meter board. Performs host DIAG reads of
//   the MTR registers (select on ds, READ_MTR strobe, sample EBUS 18:35
//   after RD_WAIT cycles) and services the MTR interrupt request (honor,
//   read interrupt-select word with ds=7, report vector/increment select).
// Ports
//   clk      : clock, all state changes on posedge
//   RESET_N  : synchronous active-low reset
//   bus      : mtr_ebus_reader_if.master (host handshake + MTR EBUS signals)
// Parameters
//   RD_WAIT   : cycles READ_MTR is held before sampling (1..15)
//   HOLDOFF   : cycles after an interrupt before mtr_int_req is looked at (0..15)
//   MAX_RETRY : extra re-reads allowed, only present with MTR_RD_RETRY_EN (1..7)
// Optional macro MTR_RD_RETRY_EN: host reads of selects 0..4 are read twice
//   and re-read until two consecutive samples agree; adds rd_err.
module mtr_ebus_reader #(
  parameter int RD_WAIT   = 2,
  parameter int HOLDOFF   = 4
`ifdef MTR_RD_RETRY_EN
  , parameter int MAX_RETRY = 3
`endif
) (
  input logic clk,
  input logic RESET_N,
  mtr_ebus_reader_if.master bus
);

  localparam logic [3:0] RD_WAIT_C = 4'(RD_WAIT);
  localparam logic [3:0] HOLDOFF_C = 4'(HOLDOFF);
`ifdef MTR_RD_RETRY_EN
  localparam logic [2:0] MAX_RETRY_C = 3'(MAX_RETRY);
`endif

  // EBUS bit n lives at index 35-n of the 18-bit vector.
  localparam int VEC_BIT  = 35 - 20;
  localparam int INCR_HI  = 35 - 21;
  localparam int INCR_LO  = 35 - 22;

  typedef enum logic [3:0] {
    IDLE,
    SETUP,
    READ,
    CAPT,
    IHONOR,
    ISETUP,
    IREAD,
    ICAPT,
    HOLD
`ifdef MTR_RD_RETRY_EN
    , CAPT2
`endif
  } state_t;

  state_t      state, state_next;
  logic [2:0]  ds_q, ds_next;
  logic        honor_q, honor_next;
  logic        done_q, done_next;
  logic        int_valid_q, int_valid_next;
  logic [17:0] rd_data_q, rd_data_next;
  logic        int_vector_q, int_vector_next;
  logic [1:0]  int_incr_q, int_incr_next;
  logic [3:0]  wait_cnt, wait_next;
  logic [3:0]  hold_cnt, hold_next;
`ifdef MTR_RD_RETRY_EN
  logic [2:0]  retry_cnt, retry_next;
  logic [17:0] sample_q, sample_next;
  logic        second_q, second_next;
  logic        rd_err_q, rd_err_next;
`endif

  // State and datapath registers; reset aborts whatever is in flight.
  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      state        <= IDLE;
      ds_q         <= 3'd0;
      honor_q      <= 1'b0;
      done_q       <= 1'b0;
      int_valid_q  <= 1'b0;
      rd_data_q    <= 18'd0;
      int_vector_q <= 1'b0;
      int_incr_q   <= 2'd0;
      wait_cnt     <= 4'd0;
      hold_cnt     <= 4'd0;
`ifdef MTR_RD_RETRY_EN
      retry_cnt    <= 3'd0;
      sample_q     <= 18'd0;
      second_q     <= 1'b0;
      rd_err_q     <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      ds_q         <= ds_next;
      honor_q      <= honor_next;
      done_q       <= done_next;
      int_valid_q  <= int_valid_next;
      rd_data_q    <= rd_data_next;
      int_vector_q <= int_vector_next;
      int_incr_q   <= int_incr_next;
      wait_cnt     <= wait_next;
      hold_cnt     <= hold_next;
`ifdef MTR_RD_RETRY_EN
      retry_cnt    <= retry_next;
      sample_q     <= sample_next;
      second_q     <= second_next;
      rd_err_q     <= rd_err_next;
`endif
    end
  end

  // Next-state and next-register logic. done/int_valid/rd_err default low
  // so they are single-cycle pulses.
  always_comb begin
    state_next      = state;
    ds_next         = ds_q;
    honor_next      = honor_q;
    done_next       = 1'b0;
    int_valid_next  = 1'b0;
    rd_data_next    = rd_data_q;
    int_vector_next = int_vector_q;
    int_incr_next   = int_incr_q;
    wait_next       = wait_cnt;
    hold_next       = hold_cnt;
`ifdef MTR_RD_RETRY_EN
    retry_next      = retry_cnt;
    sample_next     = sample_q;
    second_next     = second_q;
    rd_err_next     = 1'b0;
`endif

    case (state)
      IDLE: begin
        // Interrupt wins; a losing req is not latched and must be held.
        if (bus.mtr_int_req && (hold_cnt == 4'd0)) begin
          state_next = IHONOR;
        end else if (bus.req) begin
          ds_next    = bus.req_sel;
          state_next = SETUP;
`ifdef MTR_RD_RETRY_EN
          retry_next  = 3'd0;
          second_next = 1'b0;
`endif
        end
      end

      SETUP: begin
        wait_next  = RD_WAIT_C;
        state_next = READ;
      end

      READ: begin
        if (wait_cnt <= 4'd1) begin
          wait_next = 4'd0;
`ifdef MTR_RD_RETRY_EN
          state_next = second_q ? CAPT2 : CAPT;
`else
          state_next = CAPT;
`endif
        end else begin
          wait_next = wait_cnt - 4'd1;
        end
      end

      CAPT: begin
`ifdef MTR_RD_RETRY_EN
        // Free-running counters can tick mid-read, so they get a confirm read.
        if (ds_q <= 3'd4) begin
          sample_next = bus.ebus_data;
          second_next = 1'b1;
          wait_next   = RD_WAIT_C;
          state_next  = READ;
        end else begin
          rd_data_next = bus.ebus_data;
          done_next    = 1'b1;
          state_next   = IDLE;
        end
`else
        rd_data_next = bus.ebus_data;
        done_next    = 1'b1;
        state_next   = IDLE;
`endif
      end

`ifdef MTR_RD_RETRY_EN
      CAPT2: begin
        if (bus.ebus_data == sample_q) begin
          rd_data_next = bus.ebus_data;
          done_next    = 1'b1;
          state_next   = IDLE;
        end else if (retry_cnt >= MAX_RETRY_C) begin
          rd_data_next = bus.ebus_data;
          done_next    = 1'b1;
          rd_err_next  = 1'b1;
          state_next   = IDLE;
        end else begin
          retry_next  = retry_cnt + 3'd1;
          sample_next = bus.ebus_data;
          wait_next   = RD_WAIT_C;
          state_next  = READ;
        end
      end
`endif

      IHONOR: begin
        honor_next = 1'b1;
        ds_next    = 3'd7;
        state_next = ISETUP;
      end

      ISETUP: begin
        wait_next  = RD_WAIT_C;
        state_next = IREAD;
      end

      IREAD: begin
        if (wait_cnt <= 4'd1) begin
          wait_next  = 4'd0;
          state_next = ICAPT;
        end else begin
          wait_next = wait_cnt - 4'd1;
        end
      end

      ICAPT: begin
        int_vector_next = bus.ebus_data[VEC_BIT];
        int_incr_next   = bus.ebus_data[INCR_HI:INCR_LO];
        rd_data_next    = bus.ebus_data;
        int_valid_next  = 1'b1;
        honor_next      = 1'b0;
        hold_next       = HOLDOFF_C;
        state_next      = HOLD;
      end

      HOLD: begin
        // Leaving when the count reaches 1 (or is already 0) gives
        // max(HOLDOFF,1) cycles here and returns to IDLE with the count at 0.
        if (hold_cnt <= 4'd1) begin
          hold_next  = 4'd0;
          state_next = IDLE;
        end else begin
          hold_next = hold_cnt - 4'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.busy         = (state != IDLE);
  assign bus.done         = done_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.ds           = ds_q;
  assign bus.mtr_honor    = honor_q;
  assign bus.int_valid    = int_valid_q;
  assign bus.int_vector   = int_vector_q;
  assign bus.int_incr_sel = int_incr_q;
`ifdef MTR_RD_RETRY_EN
  assign bus.rd_err       = rd_err_q;
  assign bus.read_mtr     = (state == READ) || (state == CAPT) || (state == CAPT2) ||
                            (state == IREAD) || (state == ICAPT);
`else
  assign bus.read_mtr     = (state == READ) || (state == CAPT) ||
                            (state == IREAD) || (state == ICAPT);
`endif

endmodule
